// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler: FSM states, client count,
// plot-port field widths and a modulo-NUM_CLI index helper.
package draw_pkg;

   localparam int unsigned NUM_CLI = 3;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned X_W     = 9;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned C_W     = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      FIN   = 2'd3
   } sched_state_t;

   // (id + k) mod NUM_CLI for id, k < NUM_CLI
   function automatic logic [ID_W-1:0] cli_add(input logic [ID_W-1:0] id,
                                                input logic [ID_W-1:0] k);
      logic [ID_W:0] s;
      s = {1'b0, id} + {1'b0, k};
      if (s >= (ID_W+1)'(NUM_CLI)) s = s - (ID_W+1)'(NUM_CLI);
      return s[ID_W-1:0];
   endfunction

endpackage

// File: rtl/draw_sched_if.sv
// Client/VGA bundle of the draw scheduler; master is the scheduler side,
// slave is the clients-plus-VGA side.
interface draw_sched_if;
   import draw_pkg::*;

   logic [NUM_CLI-1:0]     req;
   logic [NUM_CLI-1:0]     cli_start;
   logic [NUM_CLI-1:0]     cli_done;
   logic [NUM_CLI*X_W-1:0] cli_x;
   logic [NUM_CLI*Y_W-1:0] cli_y;
   logic [NUM_CLI*C_W-1:0] cli_colour;
   logic [NUM_CLI-1:0]     cli_plot;
   logic [X_W-1:0]         vga_x;
   logic [Y_W-1:0]         vga_y;
   logic [C_W-1:0]         vga_colour;
   logic                   vga_plot;
   logic                   busy;
   logic [ID_W-1:0]        grant_id;
   logic                   timeout;

   modport master (
      input  req, cli_done, cli_x, cli_y, cli_colour, cli_plot,
      output cli_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout
   );

   modport slave (
      output req, cli_done, cli_x, cli_y, cli_colour, cli_plot,
      input  cli_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout
   );

endinterface

// File: rtl/draw_sched_rr_pick.sv
// Round-robin picker: first requesting client at or above ptr, with wrap-around.
module rr_pick
   import draw_pkg::*;
(
   input  logic [NUM_CLI-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [ID_W-1:0]    idx_c_o,
   output logic               valid_c_o
);

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      idx_c_o   = '0;
      valid_c_o = 1'b0;
      for (int k = int'(NUM_CLI) - 1; k >= 0; k--) begin
         if (req_i[cli_add(ptr_i, ID_W'(k))]) begin
            idx_c_o   = cli_add(ptr_i, ID_W'(k));
            valid_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_sched.sv
// Arbitrates three drawing clients onto one VGA plot port, round-robin per grant.
// Optional per-grant watchdog is built when DRAW_SCHED_WATCHDOG_EN is defined.
module draw_sched #(
   parameter int unsigned NUM_CLI = 3
`ifdef DRAW_SCHED_WATCHDOG_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 131072
`endif
) (
   input  logic          clk,
   input  logic          rst,
   draw_sched_if.master  bus
);
   import draw_pkg::*;

   sched_state_t       state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [NUM_CLI-1:0] start_q, start_d;
   logic               busy_q, busy_d;
   logic [X_W-1:0]     vx_q, vx_d;
   logic [Y_W-1:0]     vy_q, vy_d;
   logic [C_W-1:0]     vc_q, vc_d;
   logic               vplot_q, vplot_d;

   logic [ID_W-1:0]    pick_idx;
   logic               pick_vld;
   logic               wd_hit;
   logic               done_g, plot_g;
   logic [X_W-1:0]     x_g;
   logic [Y_W-1:0]     y_g;
   logic [C_W-1:0]     c_g;

   rr_pick u_rr_pick (
      .req_i     (bus.req),
      .ptr_i     (ptr_q),
      .idx_c_o   (pick_idx),
      .valid_c_o (pick_vld)
   );

   // Granted client's signals
   always_comb begin
      done_g = bus.cli_done[grant_q];
      plot_g = bus.cli_plot[grant_q];
      x_g    = '0;
      y_g    = '0;
      c_g    = '0;
      for (int i = 0; i < int'(NUM_CLI); i++) begin
         if (grant_q == ID_W'(i)) begin
            x_g = bus.cli_x[i*X_W +: X_W];
            y_g = bus.cli_y[i*Y_W +: Y_W];
            c_g = bus.cli_colour[i*C_W +: C_W];
         end
      end
   end

`ifdef DRAW_SCHED_WATCHDOG_EN
   localparam int unsigned WD_W = 18;

   logic [WD_W-1:0] wd_q, wd_d;
   logic            to_q, to_d;

   // Counter is held at zero outside START/RUN, so it starts from zero on START entry.
   always_comb begin
      wd_d   = '0;
      wd_hit = 1'b0;
      if (state_q == START || state_q == RUN) begin
         wd_d   = wd_q + WD_W'(1);
         wd_hit = (wd_d == WD_W'(TIMEOUT_CYCLES));
      end
      to_d = wd_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         to_q <= to_d;
      end
   end

   assign bus.timeout = to_q;
`else
   assign wd_hit      = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   // Next state, grant bookkeeping and registered output values
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      start_d = '0;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vc_d    = vc_q;
      vplot_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               state_d = START;
            end
         end
         START: begin
            if (wd_hit)       state_d = FIN;
            else if (!done_g) state_d = RUN;
         end
         RUN: begin
            if (wd_hit || done_g) state_d = FIN;
         end
         FIN: begin
            ptr_d   = cli_add(grant_q, ID_W'(1));
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == START || state_d == RUN) start_d[grant_d] = 1'b1;
      busy_d = (state_d != IDLE);

      // Plot samples taken on the exit cycle would land in FIN, so they are dropped.
      if (state_q == RUN && state_d == RUN) begin
         vx_d    = x_g;
         vy_d    = y_g;
         vc_d    = c_g;
         vplot_d = plot_g;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         start_q <= '0;
         busy_q  <= 1'b0;
         vx_q    <= '0;
         vy_q    <= '0;
         vc_q    <= '0;
         vplot_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vc_q    <= vc_d;
         vplot_q <= vplot_d;
      end
   end

   assign bus.cli_start  = start_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant_q;
   assign bus.vga_x      = vx_q;
   assign bus.vga_y      = vy_q;
   assign bus.vga_colour = vc_q;
   assign bus.vga_plot   = vplot_q;

endmodule

// File: tb/tb_draw_sched.sv
// Directed bench for draw_sched; the watchdog scenario is included when
// DRAW_SCHED_WATCHDOG_EN is defined (timeout shortened to 50 cycles).
module tb_draw_sched;
   import draw_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   draw_sched_if bus ();

`ifdef DRAW_SCHED_WATCHDOG_EN
   draw_sched #(.NUM_CLI(3), .TIMEOUT_CYCLES(50)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   draw_sched #(.NUM_CLI(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit auto_en  = 1'b0;
   int run_cnt[3];
   int auto_len = 3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle; optional client model drops done on start and raises it auto_len cycles later.
   task automatic step();
      @(negedge clk);
      if (auto_en) begin
         for (int i = 0; i < 3; i++) begin
            if (bus.cli_start[i]) begin
               if (run_cnt[i] == 0) bus.cli_done[i] = 1'b0;
               run_cnt[i]++;
               if (run_cnt[i] == auto_len) bus.cli_done[i] = 1'b1;
            end else begin
               run_cnt[i] = 0;
            end
         end
      end
   endtask

   task automatic wait_start(input string tag, input logic [2:0] want);
      int n = 0;
      while (bus.cli_start !== want && n < 40) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.cli_start), 32'(want));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 60) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench stalled");
      $fatal(1, "bench stalled");
   end

   initial begin
      int exp_seq[6];
      int n, last, hi;
      logic [2:0] prev, oh;
      bit early_to, lost_start;
      exp_seq = '{0, 1, 2, 0, 1, 2};

      rst            = 1'b1;
      bus.req        = '0;
      bus.cli_done   = '0;
      bus.cli_x      = '0;
      bus.cli_y      = '0;
      bus.cli_colour = '0;
      bus.cli_plot   = '0;
      for (int i = 0; i < 3; i++) run_cnt[i] = 0;
      step();
      step();
      chk("rst_busy",     32'(bus.busy),      32'd0);
      chk("rst_start",    32'(bus.cli_start), 32'd0);
      chk("rst_gid",      32'(bus.grant_id),  32'd0);
      chk("rst_vga_plot", 32'(bus.vga_plot),  32'd0);
      chk("rst_timeout",  32'(bus.timeout),   32'd0);
      rst = 1'b0;

      // All clients requesting: grants rotate, 5 cycles apart with a 2-cycle RUN
      auto_en = 1'b1;
      bus.req = 3'b111;
      n = 0; last = 0; prev = '0;
      for (int c = 0; c < 200 && !(n >= 6 && bus.busy == 1'b0); c++) begin
         step();
         if (bus.cli_start != 3'b000 && prev == 3'b000) begin
            if (n < 6) begin
               oh = 3'(1 << exp_seq[n]);
               chk($sformatf("rot_gid%0d", n), 32'(bus.grant_id), 32'(exp_seq[n]));
               chk($sformatf("rot_onehot%0d", n), 32'(bus.cli_start), 32'(oh));
               if (n > 0) chk($sformatf("rot_gap%0d", n), 32'(c - last), 32'd5);
               last = c;
            end
            n++;
            if (n == 6) bus.req = 3'b000;
         end
         prev = bus.cli_start;
      end
      chk("rot_count", 32'(n), 32'd6);
      chk("rot_idle", 32'(bus.busy), 32'd0);
      auto_en = 1'b0;

      // Client 1 alone, stale done, 20 RUN cycles; req dropped mid-grant
      bus.req = 3'b010;
      wait_start("s1_start", 3'b010);
      chk("s1_gid", 32'(bus.grant_id), 32'd1);
      hi = 1;
      step();
      if (bus.cli_start == 3'b010) hi++;
      bus.cli_done[1] = 1'b0;
      bus.req = 3'b000;
      repeat (20) begin
         step();
         if (bus.cli_start == 3'b010) hi++;
      end
      bus.cli_done[1] = 1'b1;
      step();
      chk("s1_fin_start", 32'(bus.cli_start), 32'd0);
      chk("s1_fin_busy",  32'(bus.busy),      32'd1);
      chk("s1_fin_plot",  32'(bus.vga_plot),  32'd0);
      step();
      chk("s1_idle", 32'(bus.busy), 32'd0);
      chk("s1_start_cycles", 32'(hi), 32'd22);

      // ptr should now be 2
      bus.req = 3'b111;
      wait_start("ptr2_start", 3'b100);
      chk("ptr2_gid", 32'(bus.grant_id), 32'd2);
      bus.req = 3'b000;
      bus.cli_done[2] = 1'b0;
      step();
      bus.cli_done[2] = 1'b1;
      wait_idle("ptr2_idle");

      // Plot passthrough for client 1 (ptr back at 0)
      bus.cli_x      = {9'd400, 9'd0, 9'd7};
      bus.cli_y      = {8'd200, 8'd0, 8'd9};
      bus.cli_colour = {3'b111, 3'b111, 3'b111};
      bus.req        = 3'b010;
      wait_start("plot_start", 3'b010);
      chk("plot_in_start", 32'(bus.vga_plot), 32'd0);
      bus.cli_done[1] = 1'b0;
      bus.req         = 3'b000;
      bus.cli_plot    = 3'b101;
      step();
      bus.cli_x[17:9]     = 9'd90;
      bus.cli_y[15:8]     = 8'd40;
      bus.cli_colour[5:3] = 3'b000;
      bus.cli_plot        = 3'b111;
      step();
      chk("plot_x",      32'(bus.vga_x),      32'd90);
      chk("plot_y",      32'(bus.vga_y),      32'd40);
      chk("plot_colour", 32'(bus.vga_colour), 32'd0);
      chk("plot_strobe", 32'(bus.vga_plot),   32'd1);
      bus.cli_plot    = 3'b000;
      bus.cli_x[17:9] = 9'd5;
      bus.cli_done[1] = 1'b1;
      step();
      chk("plot_fin_strobe", 32'(bus.vga_plot),  32'd0);
      chk("plot_fin_start",  32'(bus.cli_start), 32'd0);
      chk("plot_fin_hold_x", 32'(bus.vga_x),     32'd90);
      wait_idle("plot_idle");

      // Stale done on client 0 (ptr at 2): must wait in START
      bus.cli_done[0] = 1'b1;
      bus.req         = 3'b001;
      wait_start("stale_start", 3'b001);
      repeat (5) begin
         step();
         chk("stale_hold_start", 32'(bus.cli_start), 32'd1);
      end
      bus.cli_done[0] = 1'b0;
      bus.req         = 3'b000;
      step();
      chk("stale_run_start", 32'(bus.cli_start), 32'd1);

      // Reset during RUN
      rst = 1'b1;
      step();
      chk("mrst_start",   32'(bus.cli_start),  32'd0);
      chk("mrst_busy",    32'(bus.busy),       32'd0);
      chk("mrst_gid",     32'(bus.grant_id),   32'd0);
      chk("mrst_x",       32'(bus.vga_x),      32'd0);
      chk("mrst_y",       32'(bus.vga_y),      32'd0);
      chk("mrst_colour",  32'(bus.vga_colour), 32'd0);
      chk("mrst_plot",    32'(bus.vga_plot),   32'd0);
      chk("mrst_timeout", 32'(bus.timeout),    32'd0);
      rst = 1'b0;

      // ptr back at 0: req 110 grants client 1
      bus.req = 3'b110;
      wait_start("mrst_ptr_start", 3'b010);
      chk("mrst_ptr_gid", 32'(bus.grant_id), 32'd1);
      bus.req = 3'b000;
      bus.cli_done[1] = 1'b0;
      step();
      bus.cli_done[1] = 1'b1;
      wait_idle("mrst_ptr_idle");

`ifdef DRAW_SCHED_WATCHDOG_EN
      // Client 0 never finishes (ptr at 2): abort after 50 cycles
      bus.cli_done[0] = 1'b0;
      bus.req         = 3'b001;
      wait_start("wd_start", 3'b001);
      early_to = 1'b0;
      lost_start = 1'b0;
      for (int k = 1; k < 50; k++) begin
         step();
         if (bus.timeout) early_to = 1'b1;
         if (bus.cli_start != 3'b001) lost_start = 1'b1;
      end
      chk("wd_no_early_to", 32'(early_to), 32'd0);
      chk("wd_start_held",  32'(lost_start), 32'd0);
      step();
      chk("wd_timeout", 32'(bus.timeout),   32'd1);
      chk("wd_drop",    32'(bus.cli_start), 32'd0);
      chk("wd_fin",     32'(bus.busy),      32'd1);
      bus.req = 3'b011;
      step();
      chk("wd_pulse_end", 32'(bus.timeout), 32'd0);
      step();
      chk("wd_ptr_adv", 32'(bus.grant_id), 32'd1);
      bus.req = 3'b000;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/draw_sched.md
DRAW_SCHED -- requirements
Module: draw_sched

Interface
REQ-001 Parameter: NUM_CLI, 3, number of drawing clients sharing the VGA plot port (fixed at 3 for this release).
REQ-002 Parameter: TIMEOUT_CYCLES, 131072, watchdog limit per grant, in clock cycles.
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: req  in  3  per-client draw request, level-sensitive.
REQ-006 Port: cli_start  out  3  per-client start, one-hot or zero.
REQ-007 Port: cli_done  in  3  per-client done, held high until the client's next start.
REQ-008 Port: cli_x  in  27  client x coordinates, client i at bits [9i+8:9i].
REQ-009 Port: cli_y  in  24  client y coordinates, client i at bits [8i+7:8i].
REQ-010 Port: cli_colour  in  9  client colours, client i at bits [3i+2:3i].
REQ-011 Port: cli_plot  in  3  per-client plot strobe.
REQ-012 Port: vga_x / vga_y / vga_colour / vga_plot  out  9/8/3/1  muxed plot port to the VGA adapter.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.
REQ-014 Port: grant_id  out  2  index of the current or last granted client.
REQ-015 Port: timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 FSM states SHALL be IDLE, START, RUN and FIN.
REQ-017 IDLE: if any req bit is high, the block SHALL grant the first requesting index found by searching upward from ptr, with wrap-around, latch it in grant_id, and go to START next cycle; if no req bit is high, it SHALL stay in IDLE.
REQ-018 START: cli_start[grant_id] SHALL be 1; the FSM SHALL move to RUN on the first cycle cli_done[grant_id]=0, so that a stale done from the client's previous run is ignored.
REQ-019 RUN: cli_start[grant_id] SHALL stay 1; on cli_done[grant_id]=1 the FSM SHALL drive cli_start to 0 and go to FIN.
REQ-020 FIN: one cycle; ptr SHALL become (grant_id+1) mod 3; the FSM SHALL return to IDLE.
REQ-021 vga_x/y/colour/plot SHALL be registered copies of the granted client's signals with 1-cycle latency while in RUN.
REQ-022 vga_plot SHALL be 0 in IDLE, START and FIN; vga_x/y/colour SHALL hold their last value in those states.
REQ-023 cli_start bits of non-granted clients SHALL always be 0.
REQ-024 req changes during START/RUN SHALL NOT preempt the grant; dropping req[grant_id] mid-grant SHALL NOT abort it.
REQ-025 With all three req bits continuously high, grants SHALL rotate 0,1,2,0 with no client granted twice in a row.
REQ-026 Each grant SHALL occupy a minimum of 4 cycles (IDLE, START, RUN, FIN).

Reset
REQ-027 On rst=1 at a clock edge, including mid-grant, the block SHALL set state=IDLE, ptr=0, grant_id=0, cli_start=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, timeout=0 and watchdog count=0.

Configuration
REQ-028 Macro DRAW_SCHED_WATCHDOG_EN defined: an 18-bit counter SHALL clear on entry to START and increment in START/RUN.
REQ-029 With the macro defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL drop cli_start, pulse timeout for one cycle and go to FIN.
REQ-030 Macro not defined: no counter SHALL be built, timeout SHALL be tied 0, and a grant SHALL wait indefinitely for done.

Structure
REQ-031 Package draw_pkg SHALL hold the state enum sched_state_t, NUM_CLI, and the coordinate width constants X_W=9, Y_W=8, C_W=3.
REQ-032 A sub-module rr_pick SHALL be used for round-robin selection: combinational, taking 3-bit req and 2-bit ptr, producing a 2-bit index and a valid flag.

Verification
REQ-033 Scenario: req=3'b010 only; model client drops done 1 cycle after start and raises it 20 cycles later -> cli_start=3'b010 for the grant; exactly 20 RUN cycles; returns to IDLE with ptr=2.
REQ-034 Scenario: req=3'b111 held for 6 grants -> grant_id sequence 0,1,2,0,1,2.
REQ-035 Scenario: client 1 RUN emits plot at x=90, y=40, colour=3'b000 -> same values on vga_* one cycle later; vga_plot=0 in START and FIN.
REQ-036 Scenario: stale cli_done[0]=1 at grant -> FSM stays in START until done falls; no premature FIN.
REQ-037 Scenario: rst=1 asserted in RUN -> next cycle all outputs are at reset values and cli_start=0.
REQ-038 Scenario (WATCHDOG_EN defined, TIMEOUT_CYCLES=50): client never raises done -> timeout pulses on cycle 50 after START entry, and ptr advances.
